muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_div_core.sv | 71 +++++++
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op codes, FSM states
// and the most-negative-value helper.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned MAX_XLEN = 64;

  // Two's-complement most-negative value for an xlen-bit word (xlen <= MAX_XLEN).
  function automatic logic [MAX_XLEN-1:0] most_neg(input int unsigned xlen);
    logic [MAX_XLEN-1:0] v;
    v = '0;
    v[xlen-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider datapath on unsigned magnitudes: one quotient bit per step,
// loaded by start_i and advanced by step_i until done_o.
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o,
  output logic            done_o
);

  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dsor_q, dsor_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   shifted_s;
  logic [XLEN:0]   diff_s;

  assign shifted_s = {rem_q, quot_q[XLEN-1]};
  assign diff_s    = shifted_s - {1'b0, dsor_q};
  assign done_o    = (cnt_q == CW'(XLEN));
  assign quot_o    = quot_q;
  assign rem_o     = rem_q;

  // The quotient register starts as the dividend and shifts it out as quotient bits shift in.
  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    dsor_d = dsor_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      rem_d  = '0;
      quot_d = dividend_i;
      dsor_d = divisor_i;
      cnt_d  = '0;
    end else if (step_i && !done_o) begin
      if (!diff_s[XLEN]) begin
        rem_d  = diff_s[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d  = shifted_s[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b0};
      end
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      quot_q <= '0;
      dsor_q <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dsor_q <= dsor_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit (MUL..REMU) with flush support.
// Define MULDIV_EARLY_OUT_EN to let trivial divides (B=0, overflow, |B|>|A|) finish in one cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [XLEN-1:0] MOST_NEG = XLEN'(most_neg(XLEN));

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, valid_q;

  logic              accept_s;
  logic              in_signed_s;
  logic [XLEN-1:0]   in_a_mag_s, in_b_mag_s;
  logic              core_start_s, core_step_s, core_done_s;
  logic [XLEN-1:0]   core_quot_s, core_rem_s;

  logic              a_sx_s, b_sx_s;
  logic [2*XLEN-1:0] a_ext_s, b_ext_s, prod_s;
  logic [XLEN-1:0]   mul_res_s;

  logic              a_neg_s, b_neg_s, b_zero_s, ovf_s, small_s, early_s;
  logic [XLEN-1:0]   quot_fix_s, rem_fix_s, div_res_s;

  assign accept_s    = start_i && !busy_q && !flush_i;
  assign in_signed_s = ~funct3_i[0];
  assign in_a_mag_s  = (in_signed_s && operand_a_i[XLEN-1]) ? -operand_a_i : operand_a_i;
  assign in_b_mag_s  = (in_signed_s && operand_b_i[XLEN-1]) ? -operand_b_i : operand_b_i;

  assign core_start_s = accept_s && funct3_i[2];
  assign core_step_s  = (state_q == ST_DIV);

  muldiv_div_core #(.XLEN(XLEN)) u_div_core (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (core_start_s),
    .step_i     (core_step_s),
    .dividend_i (in_a_mag_s),
    .divisor_i  (in_b_mag_s),
    .quot_o     (core_quot_s),
    .rem_o      (core_rem_s),
    .done_o     (core_done_s)
  );

  // Product is formed from the latched operands; MUL_LAT only sets when it is reported.
  assign a_sx_s    = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) && a_q[XLEN-1];
  assign b_sx_s    = (op_q == OP_MULH) && b_q[XLEN-1];
  assign a_ext_s   = {{XLEN{a_sx_s}}, a_q};
  assign b_ext_s   = {{XLEN{b_sx_s}}, b_q};
  assign prod_s    = a_ext_s * b_ext_s;
  assign mul_res_s = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

  assign a_neg_s    = ~op_q[0] && a_q[XLEN-1];
  assign b_neg_s    = ~op_q[0] && b_q[XLEN-1];
  assign b_zero_s   = (b_q == '0);
  assign ovf_s      = ~op_q[0] && (a_q == MOST_NEG) && (b_q == '1);
  assign quot_fix_s = (a_neg_s ^ b_neg_s) ? -core_quot_s : core_quot_s;
  assign rem_fix_s  = a_neg_s ? -core_rem_s : core_rem_s;

`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0] a_mag_s, b_mag_s;
  assign a_mag_s = a_neg_s ? -a_q : a_q;
  assign b_mag_s = b_neg_s ? -b_q : b_q;
  assign small_s = (b_mag_s > a_mag_s);
  assign early_s = b_zero_s || ovf_s || small_s;
`else
  assign small_s = 1'b0;
  assign early_s = 1'b0;
`endif

  // Special cases override the iterated (sign-corrected) result.
  always_comb begin
    div_res_s = '0;
    if (b_zero_s) begin
      div_res_s = op_q[1] ? a_q : '1;
    end else if (ovf_s) begin
      div_res_s = op_q[1] ? '0 : a_q;
    end else if (small_s) begin
      div_res_s = op_q[1] ? a_q : '0;
    end else begin
      div_res_s = op_q[1] ? rem_fix_s : quot_fix_s;
    end
  end

  // FSM next-state and datapath capture.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_d = funct3_i[2] ? ST_DIV : ST_MUL;
          op_d    = funct3_i;
          a_d     = operand_a_i;
          b_d     = operand_b_i;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
          state_d  = ST_DONE;
          result_d = mul_res_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (early_s || core_done_s) begin
          state_d  = ST_DONE;
          result_d = div_res_s;
        end else begin
          state_d = ST_DIV;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      op_q     <= 3'b000;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= (state_d == ST_MUL) || (state_d == ST_DIV);
      valid_q  <= (state_d == ST_DONE);
    end
  end

  assign busy_o   = busy_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] opa, opb;
  logic        flush;
  logic        busy, valid;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_exp;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .MUL_LAT(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .funct3_i    (funct3),
    .operand_a_i (opa),
    .operand_b_i (opb),
    .flush_i     (flush),
    .busy_o      (busy),
    .valid_o     (valid),
    .result_o    (result)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'h0, a} & 64'h0) + sa * longint'({32'h0, b}); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        q = sa / sb; p = q; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        q = sa % sb; p = q; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint am, bm;
    if (!f[2]) return 2;
`ifdef MULDIV_EARLY_OUT_EN
    am = f[0] ? longint'({32'h0, a}) : longint'($signed(a));
    bm = f[0] ? longint'({32'h0, b}) : longint'($signed(b));
    if (am < 0) am = -am;
    if (bm < 0) bm = -bm;
    if (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || bm > am) return 1;
`else
    am = 0;
    bm = 0;
`endif
    return 33;
  endfunction

  // Issue one op at the current negedge; returns at the negedge of its VALID cycle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, output logic [31:0] res);
    int lat;
    int n;
    lat = ref_latency(f, a, b);
    last_exp = ref_result(f, a, b);
    start = 1'b1; funct3 = f; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); opa = $urandom; opb = $urandom;
    check_eq($sformatf("busy_after_accept f=%0d", f), {31'b0, busy}, 32'd1);
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (valid) break;
      if (poke && n == 3) begin
        start = 1'b1; funct3 = 3'd0; opa = 32'd3; opb = 32'd5;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq($sformatf("latency f=%0d a=%08h b=%08h", f, a, b), 32'(n), 32'(lat));
    check_eq($sformatf("result f=%0d a=%08h b=%08h", f, a, b), result, last_exp);
    check_eq("busy_in_valid_cycle", {31'b0, busy}, 32'd0);
    res = result;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 300);
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]  dir_f   [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
  logic [31:0] dir_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] dir_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                                32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] dir_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

  initial begin
    logic [31:0] res;
    bit seen;
    rst = 1'b1; start = 1'b0; funct3 = 3'd0; opa = '0; opb = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_busy", {31'b0, busy}, 32'd0);
    check_eq("reset_valid", {31'b0, valid}, 32'd0);
    check_eq("reset_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed ops, back-to-back; the divide carries a mid-flight START poke.
    for (int i = 0; i < 12; i++) begin
      run_op(dir_f[i], dir_a[i], dir_b[i], (i == 6), res);
      check_eq($sformatf("directed_%0d", i), res, dir_exp[i]);
    end

    // FLUSH together with START in the VALID cycle: not accepted.
    flush = 1'b1; start = 1'b1; funct3 = 3'd0; opa = 32'd9; opb = 32'd9;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check_eq("flush_in_done_no_accept", {31'b0, busy}, 32'd0);
    check_eq("valid_single_pulse", {31'b0, valid}, 32'd0);

    // FLUSH mid-divide: aborts silently, RESULT held.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; opa = 32'd1000; opb = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_busy", {31'b0, busy}, 32'd0);
    check_eq("flush_valid", {31'b0, valid}, 32'd0);
    check_eq("flush_result_held", result, last_exp);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    check_eq("no_valid_after_flush", {31'b0, seen}, 32'd0);

    // FLUSH and START together in IDLE: FLUSH wins.
    flush = 1'b1; start = 1'b1; funct3 = 3'd0; opa = 32'd2; opb = 32'd2;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check_eq("flush_wins_idle", {31'b0, busy}, 32'd0);
    @(negedge clk);
    run_op(3'd0, 32'd3, 32'd4, 1'b0, res);
    check_eq("mul_after_flush", res, 32'd12);

    // RESET mid-divide clears outputs immediately.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; opa = 32'd77; opb = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midop_reset_busy", {31'b0, busy}, 32'd0);
    check_eq("midop_reset_valid", {31'b0, valid}, 32'd0);
    check_eq("midop_reset_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomized ops with occasional idle gaps.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      run_op(3'($urandom), pick_operand(), pick_operand(), ($urandom_range(0, 7) == 0), res);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
